avl_bus_arbiter: RTL

AVL_BUS_ARBITER -- requirements
Module: avl_bus_arbiter

---
 rtl/avl_bus_arbiter_if.sv | 29 ++
 rtl/avl_bus_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/avl_bus_arbiter_if.sv
// Avalon-style request/response bus shared by the arbiter's requester and SDRAM ports.
interface i_avl_bus #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BEW = 4,
    parameter int BCW = 8
);
    logic [AW-1:0]  address;
    logic [BEW-1:0] byte_en;
    logic [DW-1:0]  write_data;
    logic [DW-1:0]  read_data;
    logic [BCW-1:0] burst_count;
    logic           read;
    logic           write;
    logic           begin_burst_transfer;
    logic           request_ready;
    logic           read_data_valid;
    logic           resp_ready;

    modport master (
        output address, byte_en, write_data, read, write, begin_burst_transfer, burst_count, resp_ready,
        input  request_ready, read_data, read_data_valid
    );

    modport slave (
        input  address, byte_en, write_data, read, write, begin_burst_transfer, burst_count, resp_ready,
        output request_ready, read_data, read_data_valid
    );
endinterface

// File: rtl/avl_bus_arbiter.sv
// Two-requester round-robin arbiter onto one SDRAM port, with in-order read response routing.
// Optional write-burst locking is enabled by defining AVL_ARB_BURST_LOCK_EN.
module avl_bus_arbiter #(
    parameter int OUTSTANDING_DEPTH = 4
) (
    input logic      clk,
    input logic      rest,
    i_avl_bus.slave  avl_s0,
    i_avl_bus.slave  avl_s1,
    i_avl_bus.master avl_m0
);
    localparam int PW = $clog2(OUTSTANDING_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(OUTSTANDING_DEPTH);

    typedef struct packed {
        logic [31:0] address;
        logic [3:0]  byte_en;
        logic [31:0] write_data;
        logic        read;
        logic        write;
        logic        bbt;
        logic [7:0]  burst_count;
    } req_t;

    req_t        req [2];
    req_t        sel;
    logic [1:0]  req_vld;
    logic        last_winner, hold, hold_id;
    logic        win, win_vld;
    logic        lock_active, lock_id;
    logic        full, empty, rd_block;
    logic        fwd_rd, fwd_wr, fwd_any, accept, grant_rdy;
    logic        head, push, pop;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          id_mem [OUTSTANDING_DEPTH];

    assign req[0] = '{address: avl_s0.address, byte_en: avl_s0.byte_en, write_data: avl_s0.write_data,
                      read: avl_s0.read, write: avl_s0.write, bbt: avl_s0.begin_burst_transfer,
                      burst_count: avl_s0.burst_count};
    assign req[1] = '{address: avl_s1.address, byte_en: avl_s1.byte_en, write_data: avl_s1.write_data,
                      read: avl_s1.read, write: avl_s1.write, bbt: avl_s1.begin_burst_transfer,
                      burst_count: avl_s1.burst_count};

    for (genvar i = 0; i < 2; i++) begin : g_vld
        assign req_vld[i] = req[i].read | req[i].write;
    end

`ifdef AVL_ARB_BURST_LOCK_EN
    logic [7:0] lock_cnt;
    logic       lock_id_q;

    assign lock_active = (lock_cnt != 8'd0);
    assign lock_id     = lock_id_q;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            lock_cnt  <= 8'd0;
            lock_id_q <= 1'b0;
        end else if (accept && fwd_wr) begin
            if (lock_active)
                lock_cnt <= lock_cnt - 8'd1;
            else if (sel.bbt && sel.burst_count > 8'd1) begin
                lock_cnt  <= sel.burst_count - 8'd1;
                lock_id_q <= win;
            end
        end
    end
`else
    assign lock_active = 1'b0;
    assign lock_id     = 1'b0;
`endif

    // Priority: burst lock, then a stalled owner, then round-robin on ties.
    always_comb begin
        win = 1'b0;
        if (lock_active)
            win = lock_id;
        else if (hold)
            win = hold_id;
        else if (&req_vld)
            win = ~last_winner;
        else if (req_vld[1])
            win = 1'b1;
    end

    assign win_vld  = req_vld[win];
    assign sel      = req[win];
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign rd_block = full | lock_active;

    assign fwd_rd    = !rest && win_vld && sel.read && !rd_block;
    assign fwd_wr    = !rest && win_vld && sel.write;
    assign fwd_any   = fwd_rd | fwd_wr;
    assign accept    = fwd_any && avl_m0.request_ready;
    assign grant_rdy = !rest && win_vld && avl_m0.request_ready && !(sel.read && rd_block);

    assign avl_m0.address              = sel.address;
    assign avl_m0.byte_en              = sel.byte_en;
    assign avl_m0.write_data           = sel.write_data;
    assign avl_m0.begin_burst_transfer = sel.bbt;
    assign avl_m0.burst_count          = sel.burst_count;
    assign avl_m0.read                 = fwd_rd;
    assign avl_m0.write                = fwd_wr;

    assign avl_s0.request_ready = grant_rdy && !win;
    assign avl_s1.request_ready = grant_rdy && win;

    // The FIFO head names the requester owed the next response beat.
    assign head = id_mem[rd_ptr];
    assign push = accept && fwd_rd;
    assign pop  = avl_m0.read_data_valid && avl_m0.resp_ready && !empty;

    assign avl_s0.read_data       = avl_m0.read_data;
    assign avl_s1.read_data       = avl_m0.read_data;
    assign avl_s0.read_data_valid = avl_m0.read_data_valid && !empty && !head;
    assign avl_s1.read_data_valid = avl_m0.read_data_valid && !empty && head;
    assign avl_m0.resp_ready      = empty ? 1'b1 : (head ? avl_s1.resp_ready : avl_s0.resp_ready);

    always_ff @(posedge clk) begin
        if (push)
            id_mem[wr_ptr] <= win;
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            last_winner <= 1'b1;
            hold        <= 1'b0;
            hold_id     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (accept)
                last_winner <= win;
            hold <= fwd_any && !avl_m0.request_ready;
            if (fwd_any && !avl_m0.request_ready)
                hold_id <= win;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
